reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised successor to the processor's fixed 32x32 register file. It provides two asynchronous read ports and one synchronous write port, with configurable data width and depth. It adds an optional hardwired zero register, optional write-to-read bypass, and a sequential clear sweep that zeroes every entry after reset or on request. It sits between the decode stage (read addresses) and the writeback mux (write data) of the single-cycle/pipelined MIPS datapath.

## Interface
Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_raddr1  in  ADDR_W  read address, port 1.
- i_raddr2  in  ADDR_W  read address, port 2.
- i_waddr  in  ADDR_W  write address.
- i_wdata  in  DATA_W  write data.
- i_we  in  1  write enable.
- i_clr  in  1  single-cycle request to re-zero all entries.
- o_rdata1  out  DATA_W  read data, port 1.
- o_rdata2  out  DATA_W  read data, port 2.
- o_busy  out  1  high while the clear sweep is active.

## Operation
- FSM states: CLEAR, READY.
- A 2-bit state encoding is sufficient.
- A clear counter of ADDR_W bits plus a done flag is sufficient.
- While i_rst is high:
  - state is CLEAR, with the counter asynchronously set to 0;
  - o_busy = 1;
  - o_rdata1 = o_rdata2 = 0;
  - array contents are not written.
- CLEAR behaviour:
  - each rising edge writes 0 to entry[counter], then increments the counter;
  - the edge that clears entry DEPTH-1 moves the FSM to READY;
  - o_busy is registered and goes low on that same edge;
  - i_we and i_clr are ignored;
  - both read ports return 0.
- READY behaviour:
  - a rising edge with i_we=1 writes i_wdata to entry[i_waddr];
  - exception: ZERO_REG=1 and i_waddr=0, in which case the write is dropped.
- i_clr=1 in READY:
  - moves the FSM to CLEAR with the counter at 0 on the next edge;
  - a write presented on that same edge is dropped (clear wins).
- Reads are combinational from the array, evaluated in this priority order:
  1. CLEAR → 0.
  2. ZERO_REG=1 and raddr=0 → 0.
  3. BYPASS=1, i_we=1 and raddr=i_waddr → i_wdata.
  4. Otherwise → entry[raddr].
- Bypass applies only when the write would actually be accepted: READY, i_clr=0, and the target is not the zero register.
- Reset asserted mid-sweep or mid-write aborts immediately: the FSM returns to CLEAR with the counter at 0, and the sweep restarts after release.

## Timing
- Clear sweep length: exactly DEPTH rising edges after i_rst deasserts, or after the edge that samples i_clr.
- With the defaults, o_busy falls on the 32nd edge after reset release.
- Write latency: data is visible on a non-bypassed read after the writing edge.
- With BYPASS=1 the data is visible combinationally in the same cycle.
- Read latency: 0 cycles (combinational from address).
- Widths:
  - no arithmetic on data;
  - the counter wraps DEPTH-1→0 only on the transition to READY;
  - no other wrap is permitted.
- Simultaneous read and write to the same address with BYPASS=0: the read returns the old value until the edge.

## Test plan
- Reset clear:
  - stimulus: pulse i_rst, release, count edges;
  - required: o_busy=1 for 32 edges, then 0;
  - required: reads of all 32 entries after the sweep return 0.
- Write/readback:
  - stimulus: write 32'hDEADBEEF+i to entries 1..31, then read pairs (i, i+1);
  - required: values match;
  - required: entry 0 reads 0 after a write of 32'hFEEDC0DE to addr 0 (ZERO_REG=1).
- Bypass:
  - stimulus: BYPASS=1, i_we=1, i_waddr=5, i_wdata=32'h12345678, i_raddr1=5;
  - required: o_rdata1=32'h12345678 in the same cycle;
  - stimulus: repeat with BYPASS=0;
  - required: the old value is shown until the edge.
- Clear request vs write:
  - stimulus: in READY, assert i_clr and i_we (addr 3, 32'hCAFEF00D) together;
  - required: o_busy rises next edge;
  - required: entry 3 reads 0 after the 32-cycle sweep.
- Writes during sweep:
  - stimulus: i_we=1 to addr 7 during CLEAR;
  - required: ignored, entry 7 = 0 after READY;
  - stimulus: reassert i_rst when the counter = 10;
  - required: the sweep restarts and o_busy stays high for 32 edges after release.
- Parameter sweep:
  - stimulus: DATA_W=16, ADDR_W=3, ZERO_REG=0;
  - required: 8-edge sweep;
  - required: entry 0 is writable (16'hBEEF reads back).

Source files
------------

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file: two async read ports, one write port, clear sweep
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR = 2'b01,
    S_READY = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clearing;
  logic              zero_target;
  logic              wr_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  assign clearing    = (state_q == S_CLEAR);
  assign zero_target = (ZERO_REG != 0) && (i_waddr == '0);
  // A request to clear takes precedence over a write on the same edge.
  assign wr_accept   = (state_q == S_READY) && i_we && !i_clr && !zero_target;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // The counter wraps from all-ones to zero exactly on the edge that leaves CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = S_READY;
          busy_d  = 1'b0;
        end
      end
      S_READY: begin
        if (i_clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = i_waddr;
    mem_data = i_wdata;
    if (clearing) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_data = '0;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  // The array has no reset; it is only ever zeroed by the sweep once reset is released.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) begin
      mem[mem_addr] <= mem_data;
    end
  end

  // Priority, lowest first: stored value, bypass, zero register, clearing.
  always_comb begin
    o_rdata1 = mem[i_raddr1];
    if ((BYPASS != 0) && wr_accept && (i_raddr1 == i_waddr)) begin
      o_rdata1 = i_wdata;
    end
    if ((ZERO_REG != 0) && (i_raddr1 == '0)) begin
      o_rdata1 = '0;
    end
    if (clearing) begin
      o_rdata1 = '0;
    end
  end

  always_comb begin
    o_rdata2 = mem[i_raddr2];
    if ((BYPASS != 0) && wr_accept && (i_raddr2 == i_waddr)) begin
      o_rdata2 = i_wdata;
    end
    if ((ZERO_REG != 0) && (i_raddr2 == '0)) begin
      o_rdata2 = '0;
    end
    if (clearing) begin
      o_rdata2 = '0;
    end
  end

  assign o_busy = busy_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - bench for reg_file_param: three configurations against a behavioural model
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        clr = 1'b0;

  logic [31:0] main_rd1, main_rd2, nobyp_rd1, nobyp_rd2;
  logic [15:0] small_rd1, small_rd2;
  logic        main_busy, nobyp_busy, small_busy;

  int n_checks = 0;
  int n_fail = 0;
  int n, n_small;

  reg_file_param u_main (
    .i_clk(clk), .i_rst(rst), .i_raddr1(raddr1), .i_raddr2(raddr2),
    .i_waddr(waddr), .i_wdata(wdata), .i_we(we), .i_clr(clr),
    .o_rdata1(main_rd1), .o_rdata2(main_rd2), .o_busy(main_busy)
  );

  reg_file_param #(.BYPASS(0)) u_nobyp (
    .i_clk(clk), .i_rst(rst), .i_raddr1(raddr1), .i_raddr2(raddr2),
    .i_waddr(waddr), .i_wdata(wdata), .i_we(we), .i_clr(clr),
    .o_rdata1(nobyp_rd1), .o_rdata2(nobyp_rd2), .o_busy(nobyp_busy)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_small (
    .i_clk(clk), .i_rst(rst), .i_raddr1(raddr1[2:0]), .i_raddr2(raddr2[2:0]),
    .i_waddr(waddr[2:0]), .i_wdata(wdata[15:0]), .i_we(we), .i_clr(clr),
    .o_rdata1(small_rd1), .o_rdata2(small_rd2), .o_busy(small_busy)
  );

  initial forever #5 clk = ~clk;

  // Configuration table: 0 = defaults, 1 = no bypass, 2 = 16-bit x 8 without zero register.
  function automatic int k_depth(input int k);
    return (k == 2) ? 8 : 32;
  endfunction
  function automatic int k_amask(input int k);
    return (k == 2) ? 7 : 31;
  endfunction
  function automatic logic [31:0] k_dmask(input int k);
    return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic bit k_zero(input int k);
    return k != 2;
  endfunction
  function automatic bit k_byp(input int k);
    return k != 1;
  endfunction

  logic [31:0] mdl_mem [3][32];
  int          mdl_left [3] = '{32, 32, 8};

  function automatic logic [31:0] exp_read(input int k, input logic [4:0] a);
    int ai, wi;
    ai = int'(a) & k_amask(k);
    wi = int'(waddr) & k_amask(k);
    if (rst || mdl_left[k] > 0) return 32'h0;
    if (k_zero(k) && ai == 0) return 32'h0;
    if (k_byp(k) && we && !clr && !(k_zero(k) && wi == 0) && ai == wi) return wdata & k_dmask(k);
    return mdl_mem[k][ai];
  endfunction

  function automatic logic [31:0] act_rd(input int k, input int port);
    case (k)
      0: return (port == 1) ? main_rd1 : main_rd2;
      1: return (port == 1) ? nobyp_rd1 : nobyp_rd2;
      default: return (port == 1) ? {16'h0, small_rd1} : {16'h0, small_rd2};
    endcase
  endfunction

  function automatic logic act_busy(input int k);
    case (k)
      0: return main_busy;
      1: return nobyp_busy;
      default: return small_busy;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model update: one entry per edge while sweeping, otherwise the accepted write.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int wi;
      wi = int'(waddr) & k_amask(k);
      if (rst) mdl_left[k] = k_depth(k);
      else if (mdl_left[k] > 0) begin
        mdl_mem[k][k_depth(k) - mdl_left[k]] = 32'h0;
        mdl_left[k]--;
      end else if (clr) mdl_left[k] = k_depth(k);
      else if (we && !(k_zero(k) && wi == 0)) mdl_mem[k][wi] = wdata & k_dmask(k);
    end
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cmp_busy[%0d]", k), {31'h0, act_busy(k)}, {31'h0, (rst || mdl_left[k] > 0)});
      check($sformatf("cmp_rd1[%0d] a=%0d", k, raddr1), act_rd(k, 1), exp_read(k, raddr1));
      check($sformatf("cmp_rd2[%0d] a=%0d", k, raddr2), act_rd(k, 2), exp_read(k, raddr2));
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b1;
    #1 check("reset_busy", {31'h0, main_busy}, 32'h1);
    check("reset_rd1", main_rd1, 32'h0);
    repeat (2) step();
    rst = 1'b0;

    n = 0;
    n_small = 0;
    do begin
      step();
      n++;
      if (!small_busy && n_small == 0) n_small = n;
    end while (main_busy && n < 100);
    check("reset_sweep_len", n, 32);
    check("small_sweep_len", n_small, 8);

    for (int i = 0; i < 16; i++) begin
      raddr1 = 5'(2 * i);
      raddr2 = 5'(2 * i + 1);
      #2;
      check("swept_rd1", main_rd1, 32'h0);
      check("swept_rd2", main_rd2, 32'h0);
      step();
    end

    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      waddr = 5'(i);
      wdata = 32'hDEADBEEF + 32'(i);
      step();
    end
    we = 1'b0;
    for (int i = 1; i < 31; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(i + 1);
      #2;
      check("readback_rd1", main_rd1, 32'hDEADBEEF + 32'(i));
      check("readback_rd2", main_rd2, 32'hDEADBEEF + 32'(i + 1));
      step();
    end

    raddr1 = 5'd0;
    we = 1'b1;
    waddr = 5'd0;
    wdata = 32'hFEEDC0DE;
    step();
    we = 1'b0;
    #1 check("zero_reg_main", main_rd1, 32'h0);
    check("zero_reg_small", {16'h0, small_rd1}, 32'h0000C0DE);
    we = 1'b1;
    wdata = 32'h0000BEEF;
    step();
    we = 1'b0;
    #1 check("small_entry0", {16'h0, small_rd1}, 32'h0000BEEF);
    check("zero_reg_main2", main_rd1, 32'h0);

    raddr1 = 5'd5;
    waddr = 5'd5;
    wdata = 32'h12345678;
    we = 1'b1;
    #1 check("bypass_same_cycle", main_rd1, 32'h12345678);
    check("nobyp_old_value", nobyp_rd1, 32'hDEADBEF4);
    step();
    we = 1'b0;
    #1 check("nobyp_after_edge", nobyp_rd1, 32'h12345678);

    raddr1 = 5'd3;
    raddr2 = 5'd7;
    clr = 1'b1;
    we = 1'b1;
    waddr = 5'd3;
    wdata = 32'hCAFEF00D;
    #1 check("clr_no_bypass", main_rd1, 32'hDEADBEF2);
    step();
    clr = 1'b0;
    we = 1'b0;
    check("clr_busy_rise", {31'h0, main_busy}, 32'h1);
    n = 0;
    do begin
      step();
      n++;
      we = (n >= 10 && n < 20);
      waddr = 5'd7;
      wdata = 32'h77777777;
    end while (main_busy && n < 100);
    we = 1'b0;
    check("clr_sweep_len", n, 32);
    check("clr_entry3", main_rd1, 32'h0);
    check("sweep_write_ignored", main_rd2, 32'h0);
    check("sweep_write_ignored_nb", nobyp_rd2, 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1 check("abort_busy", {31'h0, main_busy}, 32'h1);
    check("abort_rd", main_rd1, 32'h0);
    step();
    step();
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (main_busy && n < 100);
    check("restart_sweep_len", n, 32);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
